// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct, ALU control and extender encodings for the exec/mem slice
package mips_pkg;
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_SLLV  = 5'd11;
  localparam logic [4:0] ALU_SRLV  = 5'd12;
  localparam logic [4:0] ALU_SRAV  = 5'd13;
  localparam logic [4:0] ALU_PASSB = 5'd14;
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  typedef struct packed {
    logic       reg_dst;
    logic       reg_w;
    logic       alusrc;
    logic       mem_r;
    logic       mem_w;
    logic       mem2r;
    logic       beq;
    logic       bne;
    logic       jump;
    logic [1:0] ext_op;
    logic [4:0] alu_ctrl;
  } ctrl_t;
  function automatic ctrl_t imm_op(input logic [4:0] alu, input logic [1:0] ext);
    imm_op = '0;
    imm_op.reg_w = 1'b1;
    imm_op.alusrc = 1'b1;
    imm_op.alu_ctrl = alu;
    imm_op.ext_op = ext;
  endfunction
endpackage

// File: rtl/mips_alu.sv
// mips_alu: 32-bit ALU; fixed shifts use shamt, variable shifts use a[4:0]
module mips_alu
  import mips_pkg::*;
(
  input  logic [4:0]  ctrl_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o,
  output logic        zero_o
);
  always_comb begin
    y_o = '0;
    case (ctrl_i)
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_OR:    y_o = a_i | b_i;
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_NOR:   y_o = ~(a_i | b_i);
      ALU_SLT:   y_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  y_o = {31'd0, a_i < b_i};
      ALU_SLL:   y_o = b_i << shamt_i;
      ALU_SRL:   y_o = b_i >> shamt_i;
      ALU_SRA:   y_o = $signed(b_i) >>> shamt_i;
      ALU_SLLV:  y_o = b_i << a_i[4:0];
      ALU_SRLV:  y_o = b_i >> a_i[4:0];
      ALU_SRAV:  y_o = $signed(b_i) >>> a_i[4:0];
      ALU_PASSB: y_o = b_i;
      default:   y_o = '0;
    endcase
  end
  assign zero_o = y_o == '0;
endmodule

// File: rtl/mips_ctrl.sv
// mips_ctrl: main decoder from opcode/funct to datapath controls; unknown encodings decode as NOP
module mips_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic       reg_dst_o,
  output logic       reg_w_o,
  output logic       alusrc_o,
  output logic       mem_r_o,
  output logic       mem_w_o,
  output logic       mem2r_o,
  output logic       beq_o,
  output logic       bne_o,
  output logic       jump_o,
  output logic [1:0] ext_op_o,
  output logic [4:0] alu_ctrl_o
);
  ctrl_t c;
  always_comb begin
    c = '0;
    case (op_i)
      OP_R: begin
        c.reg_dst = 1'b1;
        c.reg_w = 1'b1;
        case (funct_i)
          FN_ADD, FN_ADDU: c.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: c.alu_ctrl = ALU_SUB;
          FN_AND:  c.alu_ctrl = ALU_AND;
          FN_OR:   c.alu_ctrl = ALU_OR;
          FN_XOR:  c.alu_ctrl = ALU_XOR;
          FN_NOR:  c.alu_ctrl = ALU_NOR;
          FN_SLT:  c.alu_ctrl = ALU_SLT;
          FN_SLTU: c.alu_ctrl = ALU_SLTU;
          FN_SLL:  c.alu_ctrl = ALU_SLL;
          FN_SRL:  c.alu_ctrl = ALU_SRL;
          FN_SRA:  c.alu_ctrl = ALU_SRA;
          FN_SLLV: c.alu_ctrl = ALU_SLLV;
          FN_SRLV: c.alu_ctrl = ALU_SRLV;
          FN_SRAV: c.alu_ctrl = ALU_SRAV;
          default: c = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU: c = imm_op(ALU_ADD, EXT_SIGN);
      OP_SLTI:  c = imm_op(ALU_SLT, EXT_SIGN);
      OP_SLTIU: c = imm_op(ALU_SLTU, EXT_SIGN);
      OP_ANDI:  c = imm_op(ALU_AND, EXT_ZERO);
      OP_ORI:   c = imm_op(ALU_OR, EXT_ZERO);
      OP_XORI:  c = imm_op(ALU_XOR, EXT_ZERO);
      OP_LUI:   c = imm_op(ALU_PASSB, EXT_LUI);
      OP_LW: begin
        c = imm_op(ALU_ADD, EXT_SIGN);
        c.mem_r = 1'b1;
        c.mem2r = 1'b1;
      end
      OP_SW: begin
        c = imm_op(ALU_ADD, EXT_SIGN);
        c.reg_w = 1'b0;
        c.mem_w = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.alu_ctrl = ALU_SUB;
        c.ext_op = EXT_SIGN;
        c.beq = op_i == OP_BEQ;
        c.bne = op_i == OP_BNE;
      end
      OP_J: c.jump = 1'b1;
      default: c = '0;
    endcase
  end
  assign {reg_dst_o, reg_w_o, alusrc_o, mem_r_o, mem_w_o, mem2r_o, beq_o, bne_o, jump_o, ext_op_o, alu_ctrl_o} = c;
endmodule

// File: rtl/mips_dmem.sv
// mips_dmem: word data memory, async read, sync write; reset clears every word and beats a store
module mips_dmem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wd_i,
  output logic [31:0]              rd_o
);
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst)
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (we_i)
      mem_q[addr_i] <= wd_i;
  end
  assign rd_o = mem_q[addr_i];
endmodule

// File: rtl/mips_exec_mem.sv
// mips_exec_mem: single-cycle execute/memory slice (decoder, ALU, data memory, wb and branch muxing)
module mips_exec_mem
  import mips_pkg::*;
#(
  parameter int DM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] ext_imm,
  output logic        reg_dst,
  output logic        reg_w,
  output logic [1:0]  ext_op,
  output logic        jump,
  output logic        branch_taken,
  output logic        mem_w,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] wb_data
);
  localparam int AW = $clog2(DM_DEPTH);
  logic        alusrc, mem_r, mem2r, beq, bne;
  logic [4:0]  alu_ctrl;
  logic [31:0] b, rd;
  logic        unused_fields;
  // register-number fields are consumed by the register file, not here
  assign unused_fields = ^instr[25:11];
  mips_ctrl u_ctrl (
    .op_i(instr[31:26]), .funct_i(instr[5:0]),
    .reg_dst_o(reg_dst), .reg_w_o(reg_w), .alusrc_o(alusrc), .mem_r_o(mem_r),
    .mem_w_o(mem_w), .mem2r_o(mem2r), .beq_o(beq), .bne_o(bne), .jump_o(jump),
    .ext_op_o(ext_op), .alu_ctrl_o(alu_ctrl)
  );
  assign b = alusrc ? ext_imm : rt_data;
  mips_alu u_alu (
    .ctrl_i(alu_ctrl), .a_i(rs_data), .b_i(b), .shamt_i(instr[10:6]),
    .y_o(alu_result), .zero_o(zero)
  );
  mips_dmem #(.DEPTH(DM_DEPTH)) u_dmem (
    .clk(clk), .rst(rst), .we_i(mem_w), .addr_i(alu_result[AW+1:2]),
    .wd_i(rt_data), .rd_o(rd)
  );
  assign wb_data = mem_r & mem2r ? rd : alu_result;
  assign branch_taken = beq & zero | bne & ~zero;
endmodule

// File: tb/tb_mips_exec_mem.sv
// tb_mips_exec_mem: directed vector table, memory sequences and randomized reference-model checks
module tb_mips_exec_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, rs_data, rt_data, ext_imm;
  logic        reg_dst, reg_w, jump, branch_taken, mem_w, zero;
  logic [1:0]  ext_op;
  logic [31:0] alu_result, wb_data;
  int pass_n = 0;
  int total_n = 0;

  mips_exec_mem #(.DM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .ext_imm(ext_imm), .reg_dst(reg_dst), .reg_w(reg_w), .ext_op(ext_op),
    .jump(jump), .branch_taken(branch_taken), .mem_w(mem_w),
    .alu_result(alu_result), .zero(zero), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ins, rs, rt, imm, alu;
    logic        chk_alu;
    logic [4:0]  ctl;
    logic        chk_ext;
    logic [1:0]  ext;
  } vec_t;

  typedef struct packed {
    logic        known, dst, w, j, br, mw, lw, ext_known;
    logic [1:0]  ext;
    logic [31:0] alu;
  } exp_t;

  vec_t        vecs[$];
  logic [31:0] ref_mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h0004};
  endfunction

  function automatic logic [4:0] dut_ctl();
    return {reg_dst, reg_w, jump, branch_taken, mem_w};
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] m);
    @(negedge clk);
    instr = i;
    rs_data = a;
    rt_data = b;
    ext_imm = m;
    #1;
  endtask

  task automatic add(input string n, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] imm, input logic [31:0] alu, input logic ca, input logic [4:0] ctl,
                     input logic ce, input logic [1:0] ext);
    vec_t t;
    t.name = n; t.ins = ins; t.rs = rs; t.rt = rt; t.imm = imm; t.alu = alu;
    t.chk_alu = ca; t.ctl = ctl; t.chk_ext = ce; t.ext = ext;
    vecs.push_back(t);
  endtask

  // Reference behaviour straight from the instruction semantics.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] m);
    exp_t e;
    logic [4:0] sh;
    sh = ins[10:6];
    e = '0;
    e.known = 1'b1;
    if (ins[31:26] == 6'h00) begin
      e.dst = 1'b1;
      e.w = 1'b1;
      case (ins[5:0])
        6'h20, 6'h21: e.alu = a + b;
        6'h22, 6'h23: e.alu = a - b;
        6'h24: e.alu = a & b;
        6'h25: e.alu = a | b;
        6'h26: e.alu = a ^ b;
        6'h27: e.alu = ~(a | b);
        6'h2A: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h2B: e.alu = (a < b) ? 32'd1 : 32'd0;
        6'h00: e.alu = b << sh;
        6'h02: e.alu = b >> sh;
        6'h03: e.alu = $signed(b) >>> sh;
        6'h04: e.alu = b << a[4:0];
        6'h06: e.alu = b >> a[4:0];
        6'h07: e.alu = $signed(b) >>> a[4:0];
        default: begin e = '0; e.ext_known = 1'b1; end
      endcase
    end else begin
      case (ins[31:26])
        6'h08, 6'h09: begin e.w = 1'b1; e.alu = a + m; e.ext_known = 1'b1; e.ext = 2'b01; end
        6'h0A: begin e.w = 1'b1; e.alu = ($signed(a) < $signed(m)) ? 32'd1 : 32'd0; e.ext_known = 1'b1; e.ext = 2'b01; end
        6'h0B: begin e.w = 1'b1; e.alu = (a < m) ? 32'd1 : 32'd0; e.ext_known = 1'b1; e.ext = 2'b01; end
        6'h0C: begin e.w = 1'b1; e.alu = a & m; e.ext_known = 1'b1; end
        6'h0D: begin e.w = 1'b1; e.alu = a | m; e.ext_known = 1'b1; end
        6'h0E: begin e.w = 1'b1; e.alu = a ^ m; e.ext_known = 1'b1; end
        6'h0F: begin e.w = 1'b1; e.alu = m; e.ext_known = 1'b1; e.ext = 2'b10; end
        6'h23: begin e.w = 1'b1; e.lw = 1'b1; e.alu = a + m; end
        6'h2B: begin e.mw = 1'b1; e.alu = a + m; end
        6'h04: begin e.alu = a - b; e.br = a == b; end
        6'h05: begin e.alu = a - b; e.br = a != b; end
        6'h02: begin e.j = 1'b1; e.known = 1'b0; end
        default: begin e = '0; e.ext_known = 1'b1; end
      endcase
    end
    return e;
  endfunction

  initial begin
    logic [5:0]  ops [14];
    logic [5:0]  fns [16];
    logic [31:0] ad;
    ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    // ctl = {reg_dst, reg_w, jump, branch_taken, mem_w}
    add("addu",   rtype(6'h21, 5'd0),  32'd5, 32'd7, 32'd0, 32'd12, 1'b1, 5'b11000, 1'b0, 2'b00);
    add("sub",    rtype(6'h22, 5'd0),  32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE, 1'b1, 5'b11000, 1'b0, 2'b00);
    add("slt",    rtype(6'h2A, 5'd0),  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b1, 5'b11000, 1'b0, 2'b00);
    add("sltu",   rtype(6'h2B, 5'd0),  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 5'b11000, 1'b0, 2'b00);
    add("sra",    rtype(6'h03, 5'd4),  32'd0, 32'h8000_0000, 32'd0, 32'hF800_0000, 1'b1, 5'b11000, 1'b0, 2'b00);
    add("srlv",   rtype(6'h06, 5'd0),  32'd4, 32'h8000_0000, 32'd0, 32'h0800_0000, 1'b1, 5'b11000, 1'b0, 2'b00);
    add("sll31",  rtype(6'h00, 5'd31), 32'd0, 32'd1, 32'd0, 32'h8000_0000, 1'b1, 5'b11000, 1'b0, 2'b00);
    add("nor",    rtype(6'h27, 5'd0),  32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 5'b11000, 1'b0, 2'b00);
    add("fn_bad", rtype(6'h3F, 5'd0),  32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 5'b00000, 1'b1, 2'b00);
    add("beq_eq", itype(6'h04), 32'd9, 32'd9, 32'd4, 32'd0, 1'b1, 5'b00010, 1'b0, 2'b00);
    add("bne_eq", itype(6'h05), 32'd9, 32'd9, 32'd4, 32'd0, 1'b1, 5'b00000, 1'b0, 2'b00);
    add("beq_ne", itype(6'h04), 32'd9, 32'd8, 32'd4, 32'd1, 1'b1, 5'b00000, 1'b0, 2'b00);
    add("bne_ne", itype(6'h05), 32'd9, 32'd8, 32'd4, 32'd1, 1'b1, 5'b00010, 1'b0, 2'b00);
    add("j",      itype(6'h02), 32'd3, 32'd4, 32'd4, 32'd0, 1'b0, 5'b00100, 1'b0, 2'b00);
    add("lui",    itype(6'h0F), 32'h55, 32'd0, 32'h1234_0000, 32'h1234_0000, 1'b1, 5'b01000, 1'b1, 2'b10);
    add("op_bad", itype(6'h3F), 32'd5, 32'd7, 32'd4, 32'd0, 1'b0, 5'b00000, 1'b1, 2'b00);
    add("addi",   itype(6'h08), 32'h10, 32'd0, 32'hFFFF_FFFF, 32'hF, 1'b1, 5'b01000, 1'b1, 2'b01);
    add("andi",   itype(6'h0C), 32'hFF0, 32'd0, 32'h0000_FFFF, 32'hFF0, 1'b1, 5'b01000, 1'b1, 2'b00);
    add("sltiu",  itype(6'h0B), 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'b01000, 1'b1, 2'b01);
    add("xori",   itype(6'h0E), 32'hF0F0, 32'd0, 32'h0000_FFFF, 32'h0F0F, 1'b1, 5'b01000, 1'b1, 2'b00);

    rst = 1'b1;
    instr = '0; rs_data = '0; rt_data = '0; ext_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(itype(6'h23), 32'd0, 32'd0, 32'd0);
    chk("rst_w0", wb_data, 32'd0);
    drive(itype(6'h23), 32'd0, 32'd0, 32'h3FC);
    chk("rst_w255", wb_data, 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].ins, vecs[i].rs, vecs[i].rt, vecs[i].imm);
      chk({vecs[i].name, "_ctl"}, 32'(dut_ctl()), 32'(vecs[i].ctl));
      if (vecs[i].chk_alu) begin
        chk({vecs[i].name, "_alu"}, alu_result, vecs[i].alu);
        chk({vecs[i].name, "_zero"}, 32'(zero), 32'(vecs[i].alu == 32'd0));
        chk({vecs[i].name, "_wb"}, wb_data, vecs[i].alu);
      end
      if (vecs[i].chk_ext) chk({vecs[i].name, "_ext"}, 32'(ext_op), 32'(vecs[i].ext));
    end

    // store then load, including address aliasing above bit 9
    drive(itype(6'h23), 32'h10, 32'd0, 32'd4);
    chk("lw_pre", wb_data, 32'd0);
    drive(itype(6'h2B), 32'h10, 32'hDEAD_BEEF, 32'd4);
    chk("sw_ctl", 32'(dut_ctl()), 32'(5'b00001));
    chk("sw_addr", alu_result, 32'h14);
    drive(itype(6'h23), 32'h10, 32'd0, 32'd4);
    chk("lw_wb", wb_data, 32'hDEAD_BEEF);
    chk("lw_ctl", 32'(dut_ctl()), 32'(5'b01000));
    drive(itype(6'h23), 32'h413, 32'd0, 32'd1);
    chk("lw_wrap", wb_data, 32'hDEAD_BEEF);
    drive(itype(6'h3F), 32'h10, 32'h55, 32'd4);
    drive(itype(6'h23), 32'h10, 32'd0, 32'd4);
    chk("nop_keep5", wb_data, 32'hDEAD_BEEF);
    drive(itype(6'h23), 32'h64, 32'd0, 32'd1);
    chk("nop_keep19", wb_data, 32'd0);

    // reset wins over a simultaneous store
    drive(itype(6'h2B), 32'd0, 32'h0000_AAAA, 32'd12);
    drive(itype(6'h23), 32'd0, 32'd0, 32'd12);
    chk("w3_set", wb_data, 32'h0000_AAAA);
    @(negedge clk);
    rst = 1'b1;
    instr = itype(6'h2B); rs_data = 32'd0; rt_data = 32'h0000_BBBB; ext_imm = 32'd28;
    @(posedge clk);
    #2;
    rst = 1'b0;
    instr = itype(6'h23); rt_data = 32'd0; ext_imm = 32'd12;
    #1;
    chk("rst_w3", wb_data, 32'd0);
    ext_imm = 32'd28;
    #1;
    chk("rst_w7", wb_data, 32'd0);

    foreach (ref_mem[i]) ref_mem[i] = '0;
    for (int n = 0; n < 400; n++) begin
      int k;
      logic [5:0] op, fn;
      logic [31:0] ins, a, b, m;
      exp_t e;
      k = $urandom_range(0, 15);
      op = k < 14 ? ops[k] : 6'($urandom);
      k = $urandom_range(0, 17);
      fn = k < 16 ? fns[k] : 6'($urandom);
      ins = {op, 20'($urandom), fn};
      a = $urandom;
      b = $urandom;
      m = $urandom;
      if (op == 6'h23 || op == 6'h2B) begin
        a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
        m = 32'($urandom_range(0, 3));
      end
      if ((op == 6'h04 || op == 6'h05) && $urandom_range(0, 1) == 1) b = a;
      drive(ins, a, b, m);
      e = model(ins, a, b, m);
      ad = a + m;
      chk("r_ctl", 32'(dut_ctl()), 32'({e.dst, e.w, e.j, e.br, e.mw}));
      if (e.known) begin
        chk("r_alu", alu_result, e.alu);
        chk("r_zero", 32'(zero), 32'(e.alu == 32'd0));
        chk("r_wb", wb_data, e.lw ? ref_mem[ad[9:2]] : e.alu);
      end
      if (e.ext_known) chk("r_ext", 32'(ext_op), 32'(e.ext));
      if (e.mw) ref_mem[ad[9:2]] = b;
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/mips_exec_mem.md
# mips_exec_mem

Single-cycle MIPS execute/memory slice. It combines three parts:

- the main control decoder (opcode/funct to control signals),
- the 32-bit ALU,
- a 256-word synchronous-write data memory.

It sits between the register file/extender and the write-back path. It returns write-back data, branch/jump decisions and register-file controls to the enclosing CPU.

## Interface
Parameters:
- DM_DEPTH, 256: data-memory words; the address is alu_result[9:2].

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  CPU clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- instr  in  32  current instruction word
- rs_data  in  32  register-file read port 1 (rs)
- rt_data  in  32  register-file read port 2 (rt)
- ext_imm  in  32  extended immediate from extender (mode chosen by ext_op)
- reg_dst  out  1  1: write rd (instr[15:11]); 0: write rt
- reg_w  out  1  register-file write enable
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- jump  out  1  j instruction
- branch_taken  out  1  conditional branch taken
- mem_w  out  1  data-memory write strobe (exported for display)
- alu_result  out  32  ALU output
- zero  out  1  alu_result == 0
- wb_data  out  32  mem_r&mem2r ? memory word : alu_result

## Operation
Decoding (combinational):
- R-type is op=000000, decoded by funct:
  - add 20, addu 21, sub 22, subu 23
  - and 24, or 25, xor 26, nor 27
  - slt 2A, sltu 2B
  - sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07
  - All R-type: reg_dst=1, reg_w=1, alusrc=0.
- I-type:
  - addi 08, addiu 09, slti 0A, sltiu 0B: sign-extended immediate.
  - andi 0C, ori 0D, xori 0E: zero-extended immediate.
  - lui 0F: ext_op=10, ALU PASSB.
  - lw 23: add, mem_r, mem2r, reg_w.
  - sw 2B: add, mem_w.
  - beq 04, bne 05: SUB, alusrc=0.
  - j 02: jump=1.
- Unknown op or funct: every control output is 0 (NOP). No write of any kind.

ALU:
- Internal 5-bit ctrl codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 SLLV, 12 SRLV, 13 SRAV, 14 PASSB.
- Undefined codes give result 0.
- Operand A = rs_data. Operand B = alusrc ? ext_imm : rt_data.
- Fixed shifts shift B by instr[10:6]. Variable shifts shift B by A[4:0].
- Add/sub wrap modulo 2^32. No overflow trap; add and addu behave identically.
- SLT/SLTU produce 32'h0000_0001 or 0.

Branch:
- branch_taken = (beq & zero) | (bne & ~zero).

Data memory:
- Read is asynchronous, word-addressed by alu_result[9:2].
- alu_result[1:0] and bits above 9 are ignored; the address wraps modulo 256.

## Timing
- Decoder, ALU, branch_taken, memory read and wb_data are purely combinational from instr/rs_data/rt_data/ext_imm. Zero-cycle latency.
- Store: on rising clk with mem_w=1 and rst=0, mem[alu_result[9:2]] <= rt_data.
- Same-cycle read of the address being written returns the old word. The new word is visible after the edge.
- rst=1 at a rising edge clears all DM_DEPTH words to 0. Reset takes priority over a simultaneous store.
- The block has no other state. Outputs are valid whenever inputs are; after reset, a memory read returns 0.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct localparams,
  - ALU ctrl code constants,
  - ext_op encodings.
- Sub-modules:
  - `mips_ctrl` (decoder),
  - `mips_alu`,
  - `mips_dmem`.
- The top file contains only the operand-B mux, the wb mux and the branch logic.

## Test plan
- addu: rs=5, rt=7 -> alu_result=12, reg_w=1, reg_dst=1, wb_data=12. sub with 5,7 -> 0xFFFFFFFE, zero=0.
- slt with rs=0xFFFFFFFF, rt=1 -> 1; sltu with the same operands -> 0. sra rt=0x80000000, shamt=4 -> 0xF8000000. srlv with rs=4 -> 0x08000000.
- sw with rs=0x10, imm=4, rt=0xDEADBEEF, clock edge; then lw at the same address -> wb_data=0xDEADBEEF, reg_w=1, reg_dst=0. Same-cycle read during the store returns the old value 0.
- beq with equal operands -> branch_taken=1; bne with equal operands -> 0; j -> jump=1, reg_w=0, mem_w=0.
- lui with ext_imm=0x12340000 -> alu_result=0x12340000, ext_op=10. Undefined opcode 0x3F -> all controls 0, no memory change.
- Store to word 3, then assert rst for one edge together with another store -> word 3 and the target both read 0.
